// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pkg: shared state encoding and default widths for the fetch PC controller.
package fetch_pkg;
  localparam int PC_W = 16;
  localparam int PC_STEP_DEF = 2;
  typedef enum logic [1:0] {FETCH, MISS_WAIT, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_pc_ctrl_sat_counter.sv
// sat_counter_16: 16-bit saturating event counter with sync reset and increment enable.
module sat_counter_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: next-PC select, miss/redirect buffering and halt parking; FETCH_PERF_CNT_EN adds miss/stall counters.
import fetch_pkg::*;
module fetch_pc_ctrl #(
  parameter int PC_WIDTH = PC_W,
  parameter int PC_STEP = PC_STEP_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_cur,
  input  logic                imem_valid,
  input  logic                stall_id,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt_dec,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                pc_freeze,
  output logic                imem_req,
  output logic                fetch_valid,
  output logic                flush_ifid,
  output logic                halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         miss_cycles,
  output logic [15:0]         stall_cycles
`endif
);
  fetch_state_t state, state_n;
  logic pend_valid, pend_valid_n;
  logic [PC_WIDTH-1:0] pend_target, pend_target_n, seq, pn;
  logic fz;
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH;
      pend_valid <= 1'b0;
      pend_target <= '0;
    end else begin
      state <= state_n;
      pend_valid <= pend_valid_n;
      pend_target <= pend_target_n;
    end
  always_comb begin
    seq = pc_cur + PC_WIDTH'(PC_STEP);
    state_n = state;
    pend_valid_n = pend_valid;
    pend_target_n = pend_target;
    pn = seq;
    fz = 1'b1;
    imem_req = 1'b1;
    fetch_valid = 1'b0;
    flush_ifid = 1'b0;
    halted = 1'b0;
    case (state)
      FETCH:
        if (branch_taken) begin
          flush_ifid = 1'b1;
          pn = branch_target;
          fz = ~imem_valid;
          if (!imem_valid) begin
            pend_valid_n = 1'b1;
            pend_target_n = branch_target;
            state_n = MISS_WAIT;
          end
        end else if (halt_dec) state_n = HALTED;
        else if (!imem_valid) state_n = MISS_WAIT;
        else if (!stall_id) begin
          fz = 1'b0;
          fetch_valid = 1'b1;
        end
      MISS_WAIT: begin
        flush_ifid = branch_taken;
        if (branch_taken) begin
          pend_valid_n = 1'b1;
          pend_target_n = branch_target;
        end
        if (imem_valid) begin
          state_n = FETCH;
          pend_valid_n = 1'b0;
          // A redirect completing the miss beats the sequential PC and never forwards the word.
          if (branch_taken || pend_valid) begin
            pn = branch_taken ? branch_target : pend_target;
            fz = 1'b0;
          end else begin
            fz = stall_id;
            fetch_valid = ~stall_id;
          end
        end
      end
      default: begin
        imem_req = 1'b0;
        halted = 1'b1;
      end
    endcase
    if (rst) begin
      pn = RESET_VECTOR;
      fz = 1'b0;
      imem_req = 1'b0;
      fetch_valid = 1'b0;
      flush_ifid = 1'b0;
      halted = 1'b0;
    end
  end
  assign pc_freeze = fz;
  assign pc_next = fz ? pc_cur : pn;
`ifdef FETCH_PERF_CNT_EN
  logic miss_inc, stall_inc;
  assign miss_inc = state == MISS_WAIT;
  assign stall_inc = state == FETCH && !branch_taken && !halt_dec && imem_valid && stall_id;
  sat_counter_16 u_miss (.clk(clk), .rst(rst), .inc(miss_inc), .count(miss_cycles));
  sat_counter_16 u_stall (.clk(clk), .rst(rst), .inc(stall_inc), .count(stall_cycles));
`endif
endmodule
